// File: rtl/mdu_pkg.sv
// Shared constants, opcode and state types for the RV32M multiply/divide unit.
package mdu_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // rs1 is treated as signed by these operations.
  function automatic logic op_signed_a(input mdu_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed by these operations.
  function automatic logic op_signed_b(input mdu_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative datapath: shift-add multiply and restoring divide on one hi/lo register pair,
// one bit per step, with the iteration down-counter.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] cnt;
  logic             div_mode;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // Multiply: hi accumulates, lo holds the multiplier and collects low product bits.
  // Divide: lo shifts the dividend out of its MSB and quotient bits in at its LSB.
  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    rem_sh  = {hi, lo[WIDTH-1]};
    diff    = rem_sh - {1'b0, m};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m        <= '0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      div_mode <= is_div;
      m        <= is_div ? op_b : op_a;
      hi       <= '0;
      lo       <= is_div ? op_a : op_b;
      cnt      <= CNT_W'(WIDTH - 1);
    end else if (step) begin
      cnt <= cnt - 1'b1;
      if (div_mode) begin
        if (!diff[WIDTH]) begin
          hi <= diff[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= rem_sh[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi <= add_sum[WIDTH:1];
        lo <= {add_sum[0], lo[WIDTH-1:1]};
      end
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit with Start/Busy/Done handshake.
// MDU_FAST_MUL_EN: MUL* use a single-cycle product and skip CALC; divides stay iterative.
//
// state | meaning
// IDLE  | waiting for an accepted Start
// CALC  | one iteration per cycle in mdu_iter_core
// FIX   | sign correction and half/quotient/remainder select
// DONE  | Done pulse, Result holds the answer
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Flush,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e state;
  mdu_op_e    op_in;
  mdu_op_e    op_q;

  logic             accept;
  logic             sign_a;
  logic             sign_b;
  logic             div_by_zero;
  logic             div_ovf;
  logic             corner_in;
  logic             fast_in;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] corner_val_in;

  logic             neg_q;
  logic             neg_r;
  logic             corner_q;
  logic [WIDTH-1:0] corner_val_q;

  logic [WIDTH-1:0]   core_hi;
  logic [WIDTH-1:0]   core_lo;
  logic               core_last;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_val;

  always_comb begin
    op_in  = mdu_op_e'(Funct3);
    accept = (state == IDLE) && Start && !Flush && (Funct7 == FUNCT7_MULDIV);
    sign_a = op_signed_a(op_in) & SrcA[WIDTH-1];
    sign_b = op_signed_b(op_in) & SrcB[WIDTH-1];
    mag_a  = sign_a ? -SrcA : SrcA;
    mag_b  = sign_b ? -SrcB : SrcB;

    // Divide corner cases bypass CALC; Funct3[1] separates remainder from quotient.
    div_by_zero   = Funct3[2] && (SrcB == '0);
    div_ovf       = ((op_in == OP_DIV) || (op_in == OP_REM)) && (SrcA == MOST_NEG) && (SrcB == '1);
    corner_in     = div_by_zero || div_ovf;
    corner_val_in = '0;
    if (div_by_zero)
      corner_val_in = Funct3[1] ? SrcA : '1;
    else if (div_ovf)
      corner_val_in = Funct3[1] ? '0 : SrcA;

`ifdef MDU_FAST_MUL_EN
    fast_in = !Funct3[2];
`else
    fast_in = 1'b0;
`endif
  end

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   ((state == CALC) && !Flush),
    .is_div (Funct3[2]),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .hi     (core_hi),
    .lo     (core_lo),
    .last   (core_last)
  );

`ifdef MDU_FAST_MUL_EN
  logic [WIDTH-1:0] fast_a;
  logic [WIDTH-1:0] fast_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fast_a <= '0;
      fast_b <= '0;
    end else if (accept) begin
      fast_a <= mag_a;
      fast_b <= mag_b;
    end
  end

  assign product = {{WIDTH{1'b0}}, fast_a} * {{WIDTH{1'b0}}, fast_b};
`else
  assign product = {core_hi, core_lo};
`endif

  always_comb begin
    prod_fix = neg_q ? -product : product;
    fix_val  = '0;
    case (op_q)
      OP_MUL:                       fix_val = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_val = neg_q ? -core_lo : core_lo;
      default:                      fix_val = neg_r ? -core_hi : core_hi;
    endcase
    if (corner_q)
      fix_val = corner_val_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Result       <= '0;
      op_q         <= OP_MUL;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      corner_q     <= 1'b0;
      corner_val_q <= '0;
    end else begin
      Done <= 1'b0;
      if (Flush) begin
        state <= IDLE;
        Busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              op_q         <= op_in;
              neg_q        <= sign_a ^ sign_b;
              neg_r        <= sign_a;
              corner_q     <= corner_in;
              corner_val_q <= corner_val_in;
              Busy         <= 1'b1;
              state        <= (corner_in || fast_in) ? FIX : CALC;
            end
          end
          CALC: begin
            if (core_last)
              state <= FIX;
          end
          FIX: begin
            state  <= DONE;
            Busy   <= 1'b0;
            Done   <= 1'b1;
            Result <= fix_val;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at WIDTH=32.
module tb_mul_div_unit;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic        Flush;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .Flush  (Flush),
    .Funct7 (Funct7),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  // Issues one op and returns the result, the cycle Done was seen in, and Busy cycles before it.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_cnt);
    @(negedge clk);
    Start = 1'b1; Funct7 = 7'b0000001; Funct3 = f3; SrcA = a; SrcB = b;
    @(negedge clk);
    Start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (Done) begin
        lat = cyc;
        break;
      end
      if (Busy) busy_cnt++;
      @(negedge clk);
    end
    res = Result;
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; Flush = 1'b0; Funct7 = '0; Funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Busy); else passed++;
    checks++; if (Done !== 1'b0) $display("FAIL reset_done: got %b expected 0", Done); else passed++;
    checks++; if (Result !== 32'h0) $display("FAIL reset_result: got %h expected 0", Result); else passed++;
  endtask

  task automatic test_vectors(input string tag, input vec_t v[$]);
    logic [31:0] res;
    int lat, bc;
    foreach (v[i]) begin
      run_op(v[i].f3, v[i].a, v[i].b, res, lat, bc);
      checks++;
      if (res !== v[i].exp) $display("FAIL %s_result[%0d]: got %h expected %h", tag, i, res, v[i].exp);
      else passed++;
      checks++;
      if (lat !== v[i].lat) $display("FAIL %s_latency[%0d]: got %0d expected %0d", tag, i, lat, v[i].lat);
      else passed++;
      checks++;
      if (bc !== v[i].lat - 1) $display("FAIL %s_busy_cycles[%0d]: got %0d expected %0d", tag, i, bc, v[i].lat - 1);
      else passed++;
    end
  endtask

  task automatic test_mul();
    vec_t v[$];
    v.push_back('{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT});
    v.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT});
    v.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT});
    v.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT});
    v.push_back('{3'b000, 32'h00010001, 32'h00010001, 32'h00020001, MUL_LAT});
    test_vectors("mul", v);
  endtask

  task automatic test_div();
    vec_t v[$];
    v.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT});
    v.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT});
    v.push_back('{3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT});
    v.push_back('{3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT});
    v.push_back('{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT});
    v.push_back('{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT});
    test_vectors("div", v);
  endtask

  task automatic test_div_corner();
    vec_t v[$];
    v.push_back('{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2});
    v.push_back('{3'b110, 32'd5,        32'd0,        32'd5,        2});
    v.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2});
    v.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2});
    v.push_back('{3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 2});
    test_vectors("corner", v);
  endtask

  task automatic test_start_while_busy();
    int lat = 0;
    int extra_done = 0;
    @(negedge clk);
    Start = 1'b1; Funct7 = 7'b0000001; Funct3 = 3'b101; SrcA = 32'd100; SrcB = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (Done) begin
        lat = cyc;
        break;
      end
      if (cyc == 5) begin
        Start = 1'b1; Funct3 = 3'b000; SrcA = 32'd2; SrcB = 32'd3;
      end else begin
        Start = 1'b0;
      end
      @(negedge clk);
    end
    Start = 1'b0;
    checks++; if (Result !== 32'd14) $display("FAIL busy_start_result: got %h expected %h", Result, 32'd14); else passed++;
    checks++; if (lat !== DIV_LAT) $display("FAIL busy_start_latency: got %0d expected %0d", lat, DIV_LAT); else passed++;
    repeat (4) begin
      @(negedge clk);
      if (Done || Busy) extra_done++;
    end
    checks++; if (extra_done !== 0) $display("FAIL busy_start_ignored: got %0d active cycles expected 0", extra_done); else passed++;
  endtask

  task automatic test_flush();
    int done_seen = 0;
    @(negedge clk);
    Start = 1'b1; Funct7 = 7'b0000001; Funct3 = 3'b100; SrcA = 32'd1000; SrcB = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (Busy !== 1'b1) $display("FAIL flush_busy_before: got %b expected 1", Busy); else passed++;
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    checks++; if (Busy !== 1'b0) $display("FAIL flush_busy_after: got %b expected 0", Busy); else passed++;
    repeat (40) begin
      @(negedge clk);
      if (Done) done_seen++;
    end
    checks++; if (done_seen !== 0) $display("FAIL flush_no_done: got %0d pulses expected 0", done_seen); else passed++;
    checks++; if (Result !== 32'd14) $display("FAIL flush_result_kept: got %h expected %h", Result, 32'd14); else passed++;
    Start = 1'b1; Flush = 1'b1; Funct3 = 3'b101; SrcA = 32'd50; SrcB = 32'd5;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    checks++; if (Busy !== 1'b0) $display("FAIL flush_beats_start: got busy %b expected 0", Busy); else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    Start = 1'b1; Funct7 = 7'b0000001; Funct3 = 3'b101; SrcA = 32'hFFFFFFFF; SrcB = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (Busy !== 1'b0) $display("FAIL reset_mid_busy: got %b expected 0", Busy); else passed++;
    checks++; if (Done !== 1'b0) $display("FAIL reset_mid_done: got %b expected 0", Done); else passed++;
    checks++; if (Result !== 32'h0) $display("FAIL reset_mid_result: got %h expected 0", Result); else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_funct7();
    int active = 0;
    @(negedge clk);
    Start = 1'b1; Funct7 = 7'b0000000; Funct3 = 3'b000; SrcA = 32'd2; SrcB = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    checks++; if (Busy !== 1'b0) $display("FAIL funct7_busy: got %b expected 0", Busy); else passed++;
    repeat (5) begin
      @(negedge clk);
      if (Done || Busy) active++;
    end
    checks++; if (active !== 0) $display("FAIL funct7_ignored: got %0d active cycles expected 0", active); else passed++;
  endtask

  task automatic test_back_to_back();
    int first = 0;
    int second = 0;
    logic [31:0] r1 = '0;
    logic [31:0] r2 = '0;
    @(negedge clk);
    Start = 1'b1; Funct7 = 7'b0000001; Funct3 = 3'b101; SrcA = 32'd100; SrcB = 32'd7;
    @(negedge clk);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (Done) begin
        if (first == 0) begin
          first = cyc;
          r1 = Result;
          Funct3 = 3'b111;
        end else begin
          second = cyc;
          r2 = Result;
          break;
        end
      end
      @(negedge clk);
    end
    Start = 1'b0;
    checks++; if (r1 !== 32'd14) $display("FAIL b2b_result1: got %h expected %h", r1, 32'd14); else passed++;
    checks++; if (r2 !== 32'd2) $display("FAIL b2b_result2: got %h expected %h", r2, 32'd2); else passed++;
    checks++; if (first !== DIV_LAT) $display("FAIL b2b_latency1: got %0d expected %0d", first, DIV_LAT); else passed++;
    checks++;
    if (second - first !== DIV_LAT + 1) $display("FAIL b2b_spacing: got %0d expected %0d", second - first, DIV_LAT + 1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_corner();
    test_start_while_busy();
    test_flush();
    test_reset_mid();
    test_funct7();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
